gpio_cfg_serial_loader: RTL and testbench

//  Sequencer that programs the mprj_io pad configuration chains. Reads one CFG_BITS word per pad

---
 rtl/gpio_cfg_pkg.sv | 24 ++
 rtl/gpio_cfg_bit_timer.sv | 49 ++++
 rtl/gpio_cfg_serial_loader.sv | 182 ++++++++++++++++++
 tb/tb_gpio_cfg_serial_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the pad configuration serial loader: default
// geometry, FSM state encoding and common pad mode words.
package gpio_cfg_pkg;

  localparam int NUM_IO_DEFAULT   = 38;
  localparam int CFG_BITS_DEFAULT = 13;
  localparam int CLK_DIV_DEFAULT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_FETCH_C = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_LOAD    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Typical pad mode words held in the config store.
  localparam logic [CFG_BITS_DEFAULT-1:0] GPIO_MODE_MGMT_STD_INPUT_NOPULL = 13'h0403;
  localparam logic [CFG_BITS_DEFAULT-1:0] GPIO_MODE_MGMT_STD_OUTPUT       = 13'h1809;
  localparam logic [CFG_BITS_DEFAULT-1:0] GPIO_MODE_USER_STD_OUTPUT       = 13'h1808;

endpackage

// File: rtl/gpio_cfg_bit_timer.sv
// Bit-period timer: one bit is CLK_DIV low cycles followed by CLK_DIV high
// cycles. Strobes are only valid while en is high; the count restarts at 0
// whenever en drops, so each enable window starts on a fresh low phase.
module gpio_cfg_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic resetb,
  input  logic en,
  output logic phase_low_first,
  output logic rise,
  output logic bit_end
);

  localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: free-run over one bit period while enabled, else park at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Period counter register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // rise marks the last low cycle (the clock goes high on the next edge);
  // bit_end marks the last high cycle.
  assign phase_low_first = en && (cnt_q == '0);
  assign rise            = en && (cnt_q == CNT_RISE);
  assign bit_end         = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Pad configuration sequencer: fetches one word per pad from the config
// store and shifts the pairs into two daisy-chained pad control chains
// (far end first, MSB first), then pulses serial_load to latch every pad.
module gpio_cfg_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_IO   = NUM_IO_DEFAULT,
  parameter int CFG_BITS = CFG_BITS_DEFAULT,
  parameter int CLK_DIV  = CLK_DIV_DEFAULT
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      start,
  input  logic                      abort,
  output logic [$clog2(NUM_IO)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]       cfg_data,
  output logic                      serial_clock,
  output logic                      serial_load,
  output logic                      serial_data_1,
  output logic                      serial_data_2,
  output logic                      busy,
  output logic                      done
);

  localparam int HALF   = NUM_IO / 2;
  localparam int ADDR_W = $clog2(NUM_IO);
  localparam int STEP_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W  = $clog2(CFG_BITS + 1);

  localparam logic [ADDR_W-1:0] HALF_M1   = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] HALF_A    = ADDR_W'(HALF);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CFG_BITS);

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [CFG_BITS-1:0] sr_1_q;
  logic [CFG_BITS-1:0] sr_2_q;
  logic [ADDR_W-1:0]   cfg_addr_q;
  logic                serial_clock_q;
  logic                serial_load_q;
  logic                serial_data_1_q;
  logic                serial_data_2_q;
  logic                busy_q;
  logic                done_q;

  logic [STEP_W-1:0] step_inc;
  logic              timer_en;
  logic              phase_low_first;
  logic              rise;
  logic              bit_end;

  assign step_inc = step_q + STEP_W'(1);

  // The timer also paces LOAD: there, rise marks the last of CLK_DIV cycles.
  assign timer_en = (state_q == ST_SHIFT) || (state_q == ST_LOAD);

  gpio_cfg_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clock          (clock),
    .resetb         (resetb),
    .en             (timer_en),
    .phase_low_first(phase_low_first),
    .rise           (rise),
    .bit_end        (bit_end)
  );

  // Sequencer FSM with all outputs registered; abort outside IDLE returns
  // everything to the reset values on the next edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q         <= ST_IDLE;
      step_q          <= '0;
      bit_cnt_q       <= '0;
      sr_1_q          <= '0;
      sr_2_q          <= '0;
      cfg_addr_q      <= '0;
      serial_clock_q  <= 1'b0;
      serial_load_q   <= 1'b0;
      serial_data_1_q <= 1'b0;
      serial_data_2_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else if ((state_q != ST_IDLE) && abort) begin
      state_q         <= ST_IDLE;
      step_q          <= '0;
      bit_cnt_q       <= '0;
      sr_1_q          <= '0;
      sr_2_q          <= '0;
      cfg_addr_q      <= '0;
      serial_clock_q  <= 1'b0;
      serial_load_q   <= 1'b0;
      serial_data_1_q <= 1'b0;
      serial_data_2_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_q    <= '0;
          bit_cnt_q <= '0;
          if (start && !abort) begin
            state_q    <= ST_FETCH_A;
            busy_q     <= 1'b1;
            cfg_addr_q <= HALF_M1;
          end
        end
        ST_FETCH_A: begin
          state_q    <= ST_FETCH_B;
          cfg_addr_q <= HALF_A + ADDR_W'(step_q);
        end
        ST_FETCH_B: begin
          state_q <= ST_FETCH_C;
          sr_1_q  <= cfg_data;
        end
        ST_FETCH_C: begin
          // Present both MSBs for the first low cycle and pre-shift.
          state_q         <= ST_SHIFT;
          serial_data_1_q <= sr_1_q[CFG_BITS-1];
          serial_data_2_q <= cfg_data[CFG_BITS-1];
          sr_1_q          <= {sr_1_q[CFG_BITS-2:0], 1'b0};
          sr_2_q          <= {cfg_data[CFG_BITS-2:0], 1'b0};
        end
        ST_SHIFT: begin
          if (phase_low_first) begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
          if (rise) begin
            serial_clock_q <= 1'b1;
          end
          if (bit_end) begin
            serial_clock_q <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (step_q == LAST_STEP) begin
                state_q       <= ST_LOAD;
                serial_load_q <= 1'b1;
              end else begin
                state_q    <= ST_FETCH_A;
                step_q     <= step_inc;
                cfg_addr_q <= HALF_M1 - ADDR_W'(step_inc);
              end
            end else begin
              serial_data_1_q <= sr_1_q[CFG_BITS-1];
              serial_data_2_q <= sr_2_q[CFG_BITS-1];
              sr_1_q          <= {sr_1_q[CFG_BITS-2:0], 1'b0};
              sr_2_q          <= {sr_2_q[CFG_BITS-2:0], 1'b0};
            end
          end
        end
        ST_LOAD: begin
          if (rise) begin
            state_q         <= ST_DONE;
            serial_load_q   <= 1'b0;
            done_q          <= 1'b1;
            serial_data_1_q <= 1'b0;
            serial_data_2_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_addr      = cfg_addr_q;
  assign serial_clock  = serial_clock_q;
  assign serial_load   = serial_load_q;
  assign serial_data_1 = serial_data_1_q;
  assign serial_data_2 = serial_data_2_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench for gpio_cfg_serial_loader: a cycle-indexed output model plus pad
// chain models, driven by directed runs on a 38-pad and a 4-pad instance.
module tb_gpio_cfg_serial_loader;

  localparam int NI    = 38;
  localparam int B     = 13;
  localparam int D     = 4;
  localparam int HALF  = NI / 2;
  localparam int P     = 3 + 2 * B * D;
  localparam int TDONE = 1 + HALF * P + D;
  localparam int NI_S  = 4;
  localparam int D_S   = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetb, start, abort;
  logic [5:0]    cfg_addr;
  logic [B-1:0]  cfg_data;
  logic          serial_clock, serial_load, serial_data_1, serial_data_2, busy, done;
  logic          start_s, abort_s;
  logic [1:0]    cfg_addr_s;
  logic [B-1:0]  cfg_data_s;
  logic          sc_s, sl_s, sd1_s, sd2_s, busy_s, done_s;

  logic [B-1:0]  store   [NI];
  logic [B-1:0]  store_s [NI_S];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gpio_cfg_serial_loader #(.NUM_IO(NI), .CFG_BITS(B), .CLK_DIV(D)) dut (
    .clock(clock), .resetb(resetb), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .serial_clock(serial_clock), .serial_load(serial_load),
    .serial_data_1(serial_data_1), .serial_data_2(serial_data_2),
    .busy(busy), .done(done)
  );

  gpio_cfg_serial_loader #(.NUM_IO(NI_S), .CFG_BITS(B), .CLK_DIV(D_S)) dut_s (
    .clock(clock), .resetb(resetb), .start(start_s), .abort(abort_s),
    .cfg_addr(cfg_addr_s), .cfg_data(cfg_data_s),
    .serial_clock(sc_s), .serial_load(sl_s),
    .serial_data_1(sd1_s), .serial_data_2(sd2_s),
    .busy(busy_s), .done(done_s)
  );

  // Registered config stores: data valid the cycle after the address.
  always @(posedge clock) cfg_data   <= store[cfg_addr];
  always @(posedge clock) cfg_data_s <= store_s[cfg_addr_s];
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Pad chain models: shift on serial_clock rise, latch on serial_load rise.
  logic [HALF*B-1:0] ch1, ch2, lat1, lat2;
  logic [2*B-1:0]    ch1_s, ch2_s, lat1_s, lat2_s;
  int rises = 0;
  int loads = 0;
  int dones = 0;
  always @(posedge serial_clock) begin
    ch1   <= {ch1[HALF*B-2:0], serial_data_1};
    ch2   <= {ch2[HALF*B-2:0], serial_data_2};
    rises <= rises + 1;
  end
  always @(posedge serial_load) begin
    lat1  <= ch1;
    lat2  <= ch2;
    loads <= loads + 1;
  end
  always @(negedge clock) if (done) dones <= dones + 1;
  always @(posedge sc_s) begin
    ch1_s <= {ch1_s[2*B-2:0], sd1_s};
    ch2_s <= {ch2_s[2*B-2:0], sd2_s};
  end
  always @(posedge sl_s) begin
    lat1_s <= ch1_s;
    lat2_s <= ch2_s;
  end

  // Run tracker: m_t is the cycle index since start was sampled (1 = first fetch).
  bit m_run = 1'b0;
  int m_t   = 0;
  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1'b1;
        m_t   = 1;
      end
    end else if (abort || m_t == TDONE) begin
      m_run = 1'b0;
    end else begin
      m_t = m_t + 1;
    end
  end

  // Expected {busy, done, serial_clock, serial_load, data_1, data_2} at cycle t.
  function automatic logic [5:0] model_out(input int t);
    int u, k, r, q, bitn;
    logic sc, ld, d1, d2, dn;
    u = t - 1; k = u / P; r = u % P;
    sc = 1'b0; ld = 1'b0; d1 = 1'b0; d2 = 1'b0; dn = 1'b0;
    if (k < HALF) begin
      if (r < 3) begin
        if (k > 0) begin
          d1 = store[HALF-k][0];
          d2 = store[HALF+k-1][0];
        end
      end else begin
        q    = r - 3;
        bitn = q / (2 * D);
        sc   = ((q % (2 * D)) >= D);
        d1   = store[HALF-1-k][B-1-bitn];
        d2   = store[HALF+k][B-1-bitn];
      end
    end else if (u - HALF * P < D) begin
      ld = 1'b1;
      d1 = store[0][0];
      d2 = store[NI-1][0];
    end else begin
      dn = 1'b1;
    end
    return {1'b1, dn, sc, ld, d1, d2};
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clock) begin : cmp
    logic [5:0] e;
    int u;
    if (resetb) begin
      e = m_run ? model_out(m_t) : 6'b0;
      check("outputs", int'({busy, done, serial_clock, serial_load, serial_data_1, serial_data_2}),
            int'(e));
      u = m_t - 1;
      if (m_run && (u / P) < HALF && (u % P) == 0)
        check("addr_fetch_a", int'(cfg_addr), HALF - 1 - u / P);
      if (m_run && (u / P) < HALF && (u % P) == 1)
        check("addr_fetch_b", int'(cfg_addr), HALF + u / P);
    end
  end

  // Pulse start now, run len cycles; optional re-pulses and one abort.
  task automatic run_window(input int len, input int pa, input int pb, input int ab,
                            output int done_rel);
    int s0, rel;
    done_rel = -1;
    s0 = cyc;
    start = 1'b1;
    for (int n = 0; n < len; n++) begin
      @(negedge clock);
      rel   = cyc - s0;
      start = (rel == pa) || (rel == pb);
      abort = (rel == ab);
      if (rel == 1) check("start_accepted", int'(busy), 1);
      if (ab > 0 && rel == ab + 1)
        check("abort_idle", int'({busy, done, serial_clock, serial_load, serial_data_1, serial_data_2}), 0);
      if (done && done_rel < 0) done_rel = rel;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_pads(input string name);
    for (int j = 0; j < HALF; j++) begin
      check(name, int'(lat1[j*B +: B]), int'(store[j]));
      check(name, int'(lat2[(HALF-1-j)*B +: B]), int'(store[HALF+j]));
    end
  endtask

  initial begin
    int drel, r0, l0, n0, s1, rel, got;
    resetb = 1'b0; start = 1'b0; abort = 1'b0; start_s = 1'b0; abort_s = 1'b0;
    for (int i = 0; i < NI; i++) store[i] = B'(32'h1000 | i);
    store_s[0] = 13'h1234; store_s[1] = 13'h0F0F; store_s[2] = 13'h1ACE; store_s[3] = 13'h0357;
    repeat (3) @(negedge clock);
    check("reset_outputs",
          int'({busy, done, serial_clock, serial_load, serial_data_1, serial_data_2, cfg_addr}), 0);
    resetb = 1'b1;
    @(negedge clock);

    // Full load with stray starts at cycles 10 and 1500.
    r0 = rises; l0 = loads; n0 = dones;
    run_window(2100, 10, 1500, -1, drel);
    $display("run1: done at cycle %0d", drel);
    check("done_latency", drel, 2038);
    check("done_count", dones - n0, 1);
    check("load_count", loads - l0, 1);
    check("rise_count", rises - r0, 247);
    check("pad_literal_0", int'(lat1[B-1:0]), 32'h1000);
    check("pad_literal_37", int'(lat2[B-1:0]), 32'h1025);
    check_pads("pad");

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    $display("start+abort: busy=%0d", busy);
    check("start_abort_busy", int'(busy), 0);
    @(negedge clock);
    check("start_abort_busy2", int'(busy), 0);

    // Abort at cycle 500, then restart with new contents.
    for (int i = 0; i < NI; i++) store[i] = B'((i * 173) ^ 32'h0555);
    l0 = loads; n0 = dones;
    run_window(2100, -1, -1, 500, drel);
    $display("abort run: loads=%0d dones=%0d", loads - l0, dones - n0);
    check("abort_no_done", dones - n0, 0);
    check("abort_no_load", loads - l0, 0);
    run_window(2100, -1, -1, -1, drel);
    $display("restart: done at cycle %0d", drel);
    check("restart_latency", drel, 2038);
    check_pads("pad_restart");

    // Async reset mid-run, then immediate restart.
    run_window(300, -1, -1, -1, drel);
    #2 resetb = 1'b0;
    #1 check("async_reset_outputs",
             int'({busy, done, serial_clock, serial_load, serial_data_1, serial_data_2, cfg_addr}), 0);
    @(negedge clock);
    resetb = 1'b1;
    run_window(2100, -1, -1, -1, drel);
    $display("after reset: done at cycle %0d", drel);
    check("reset_restart_latency", drel, 2038);

    // Small instance: 4 pads, CLK_DIV=1.
    s1 = cyc; got = -1;
    start_s = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clock);
      start_s = 1'b0;
      rel = cyc - s1;
      if (rel == 1)  check("small_addr_k0_a", int'(cfg_addr_s), 1);
      if (rel == 2)  check("small_addr_k0_b", int'(cfg_addr_s), 2);
      if (rel == 30) check("small_addr_k1_a", int'(cfg_addr_s), 0);
      if (rel == 31) check("small_addr_k1_b", int'(cfg_addr_s), 3);
      if (done_s && got < 0) got = rel;
    end
    $display("small: done at cycle %0d", got);
    check("small_latency", got, 60);
    check("small_pad0", int'(lat1_s[B-1:0]), 32'h1234);
    check("small_pad1", int'(lat1_s[2*B-1:B]), 32'h0F0F);
    check("small_pad2", int'(lat2_s[2*B-1:B]), 32'h1ACE);
    check("small_pad3", int'(lat2_s[B-1:0]), 32'h0357);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
